// File: rtl/serial_compare_ctrl.sv
// ============================================================================
// serial_compare_ctrl : bit-serial MSB-first magnitude compare built around one
// external 1-bit equality comparator. Optional macro: EARLY_EXIT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_x,
  output logic             cmp_y,
  input  logic             cmp_z,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IDX_W-1:0] idx;
  logic             mism, gt_r;
  logic             bit_mism, mism_nx, gt_nx;

  always_comb begin
    cmp_x    = 1'b0;
    cmp_y    = 1'b0;
    state_nx = state;
    bit_mism = ~cmp_z;
    mism_nx  = mism | bit_mism;
    // The first (most significant) mismatch decides; A's bit there is 1 iff A > B.
    gt_nx    = mism ? gt_r : a_sh[WIDTH-1];
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: if (start) state_nx = SCAN;
      SCAN: begin
        cmp_x = a_sh[WIDTH-1];
        cmp_y = b_sh[WIDTH-1];
        if (idx == '0) state_nx = DONE;
`ifdef EARLY_EXIT_EN
        if (bit_mism) state_nx = DONE;
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      idx  <= '0;
      mism <= 1'b0;
      gt_r <= 1'b0;
      eq   <= 1'b0;
      gt   <= 1'b0;
      lt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            idx  <= IDX_MSB;
            mism <= 1'b0;
            gt_r <= 1'b0;
          end
        end
        SCAN: begin
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          idx  <= idx - 1'b1;
          if (!mism && bit_mism) begin
            mism <= 1'b1;
            gt_r <= a_sh[WIDTH-1];
          end
          if (state_nx == DONE) begin
            eq <= ~mism_nx;
            gt <= mism_nx & gt_nx;
            lt <= mism_nx & ~gt_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
